// File: rtl/led_switch_io_pkg.sv
// Shared constants for the LED/switch IO responder: bus addresses, halfword select, default widths.
package led_switch_io_pkg;

    localparam logic [31:0] LED_LO_ADDR = 32'hfffffc60;
    localparam logic [31:0] LED_HI_ADDR = 32'hfffffc62;
    localparam logic [31:0] SW_LO_ADDR  = 32'hfffffc70;
    localparam logic [31:0] SW_HI_ADDR  = 32'hfffffc72;

    localparam int unsigned HALF_SEL_BIT  = 1;
    localparam int unsigned DEFAULT_LED_W = 24;
    localparam int unsigned DEFAULT_SW_W  = 24;

    typedef enum logic {
        HalfLo = 1'b0,
        HalfHi = 1'b1
    } half_e;

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchronizer for raw board switches, followed by a debounce filter when
// SWITCH_DEBOUNCE_EN is defined; otherwise the synchronized vector is registered directly.
module switch_debouncer
    import led_switch_io_pkg::*;
#(
    parameter int unsigned SW_W            = DEFAULT_SW_W,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [SW_W-1:0] raw,
    output logic [SW_W-1:0] stable
);

    logic [SW_W-1:0] sync1;
    logic [SW_W-1:0] sync2;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef SWITCH_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_W-1:0]  candidate;
    logic [CNT_W-1:0] cnt;

    // Any change restarts the count; the counter saturates once the vector is accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            candidate <= '0;
            cnt       <= '0;
            stable    <= '0;
        end else if (sync2 != candidate) begin
            candidate <= sync2;
            cnt       <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= candidate;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end
`else
    logic [31:0] unused_cfg;
    assign unused_cfg = 32'(DEBOUNCE_CYCLES);

    always_ff @(posedge clock) begin
        if (reset) begin
            stable <= '0;
        end else begin
            stable <= sync2;
        end
    end
`endif

endmodule

// File: rtl/led_switch_io.sv
// IO-bus target for the board LEDs (halfword writes/readback) and debounced switches.
// Define SWITCH_DEBOUNCE_EN to enable the switch debounce filter in switch_debouncer.
module led_switch_io
    import led_switch_io_pkg::*;
#(
    parameter int unsigned LED_W           = DEFAULT_LED_W,
    parameter int unsigned SW_W            = DEFAULT_SW_W,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ioRead,
    input  logic             ioWrite,
    input  logic             LEDCtrl,
    input  logic             SwitchCtrl,
    input  logic [1:0]       addr_low,
    input  logic [31:0]      write_data,
    output logic [15:0]      io_rdata,
    input  logic [SW_W-1:0]  switch_in,
    output logic [LED_W-1:0] led_out
);

    logic [LED_W-1:0] led;
    logic [SW_W-1:0]  stable;
    half_e            half;
    logic             unused_bits;

    assign half        = half_e'(addr_low[HALF_SEL_BIT]);
    assign led_out     = led;
    assign unused_bits = ^{write_data[31:16], addr_low[0]};

    switch_debouncer #(
        .SW_W            (SW_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_switch_debouncer (
        .clock  (clock),
        .reset  (reset),
        .raw    (switch_in),
        .stable (stable)
    );

    // LEDCtrl takes priority over SwitchCtrl, so a write with both selects still lands here.
    always_ff @(posedge clock) begin
        if (reset) begin
            led <= '0;
        end else if (ioWrite && LEDCtrl) begin
            unique case (half)
                HalfLo: led[15:0]       <= write_data[15:0];
                HalfHi: led[LED_W-1:16] <= write_data[LED_W-17:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        io_rdata = 16'h0000;
        if (ioRead && LEDCtrl) begin
            io_rdata = (half == HalfHi) ? 16'(led[LED_W-1:16]) : led[15:0];
        end else if (ioRead && SwitchCtrl) begin
            io_rdata = (half == HalfHi) ? 16'(stable[SW_W-1:16]) : stable[15:0];
        end
    end

endmodule
